// File: rtl/morse_key_classifier_pkg.sv
// Shared symbol encodings and classifier state type for the Morse front end.
// alphaFSM imports the same package so both ends agree on the codes.
package morse_key_classifier_pkg;

    typedef enum logic [2:0] {
        SYM_WAIT  = 3'd0,
        SYM_DIT   = 3'd1,
        SYM_DAH   = 3'd2,
        SYM_GAP   = 3'd3,
        SYM_SPACE = 3'd4
    } symbol_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS      = 2'd1,
        RELEASE    = 2'd2,
        LETTER_GAP = 2'd3
    } state_e;

    // Bits needed to hold values 0..max inclusive.
    function automatic int unsigned count_width(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/morse_key_classifier_unit_timer.sv
// Morse time-unit prescaler: one-cycle tick every UNIT_CYCLES clocks,
// re-phased so the cycle carrying restart counts as position zero.
module unit_timer #(
    parameter int unsigned UNIT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic resetN,
    input  logic restart,
    output logic tick
);
    import morse_key_classifier_pkg::*;

    localparam int unsigned PW = count_width(UNIT_CYCLES - 1);
    localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] count;
    logic [PW-1:0] current;

    // The restart cycle itself is unit position 0, so units line up with the edge.
    assign current = restart ? '0 : count;
    assign tick    = (current == LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= current + PW'(1);
        end
    end

endmodule

// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronizes the raw key, times presses and releases
// in Morse units, and emits single-cycle DIT/DAH/GAP/SPACE codes for alphaFSM.
module morse_key_classifier #(
    parameter int unsigned UNIT_CYCLES = 25000000,
    parameter int unsigned DAH_UNITS   = 2,
    parameter int unsigned GAP_UNITS   = 3,
    parameter int unsigned SPACE_UNITS = 7
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       keyIn,
    output logic [2:0] inputSignal,
    output logic       keyLevel
);
    import morse_key_classifier_pkg::*;

    localparam int unsigned CW = count_width(SPACE_UNITS);
    localparam logic [CW-1:0] DAH_C   = CW'(DAH_UNITS);
    localparam logic [CW-1:0] GAP_M1  = CW'(GAP_UNITS - 1);
    localparam logic [CW-1:0] SPC_M1  = CW'(SPACE_UNITS - 1);
    localparam logic [CW-1:0] SPC_MAX = CW'(SPACE_UNITS);

    logic          key_meta;
    logic          key_s;
    logic          key_prev;
    logic          key_edge;
    logic          tick;
    logic [CW-1:0] unit_count;
    state_e        state;
    state_e        state_nxt;
    symbol_e       sym_nxt;
    symbol_e       sym_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_meta <= keyIn;
            key_s    <= key_meta;
            key_prev <= key_s;
        end
    end

    assign key_edge = key_s ^ key_prev;

    unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_unit_timer (
        .clk     (clk),
        .resetN  (resetN),
        .restart (key_edge),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            unit_count <= '0;
        end else if (key_edge) begin
            unit_count <= '0;
        end else if (tick && (unit_count != SPC_MAX)) begin
            unit_count <= unit_count + CW'(1);
        end
    end

    // Edges are tested first in every state so they beat a coincident threshold.
    always_comb begin
        state_nxt = state;
        sym_nxt   = SYM_WAIT;
        unique case (state)
            IDLE: begin
                if (key_edge && key_s) begin
                    state_nxt = PRESS;
                end
            end
            PRESS: begin
                if (key_edge && !key_s) begin
                    sym_nxt   = (unit_count < DAH_C) ? SYM_DIT : SYM_DAH;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (key_edge) begin
                    state_nxt = PRESS;
                end else if (tick && (unit_count == GAP_M1)) begin
                    sym_nxt   = SYM_GAP;
                    state_nxt = LETTER_GAP;
                end
            end
            LETTER_GAP: begin
                if (key_edge) begin
                    state_nxt = PRESS;
                end else if (tick && (unit_count == SPC_M1)) begin
                    sym_nxt   = SYM_SPACE;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            sym_q <= SYM_WAIT;
        end else begin
            state <= state_nxt;
            sym_q <= sym_nxt;
        end
    end

    assign inputSignal = sym_q;
    assign keyLevel    = key_s;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Bench for morse_key_classifier: directed scenarios plus random key traffic
// against a run-length model of the key line.
module tb_morse_key_classifier;
    import morse_key_classifier_pkg::*;

    localparam int U       = 4;
    localparam int DAH_U   = 2;
    localparam int GAP_U   = 3;
    localparam int SPACE_U = 7;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       keyIn = 1'b0;
    logic [2:0] inputSignal;
    logic       keyLevel;

    int nchecks = 0;
    int nerr = 0;
    int cyc = 0;
    int seen[$];
    int want[$];

    // Reference: run length of the sampled key level; a symbol decided on
    // sample k is due on the output two clocks later.
    int         m_len;
    int         m_phase;
    logic       m_level;
    logic [2:0] ev;
    logic [2:0] d1;
    logic [2:0] d2;
    logic [2:0] m_out;
    logic       m_s1;
    logic       m_kl;

    always #5 clk = ~clk;

    morse_key_classifier #(
        .UNIT_CYCLES (U),
        .DAH_UNITS   (DAH_U),
        .GAP_UNITS   (GAP_U),
        .SPACE_UNITS (SPACE_U)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .keyIn       (keyIn),
        .inputSignal (inputSignal),
        .keyLevel    (keyLevel)
    );

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_len = 0; m_phase = 0; m_level = 1'b0;
            d1 = 3'd0; d2 = 3'd0; m_out = 3'd0;
            m_s1 = 1'b0; m_kl = 1'b0;
        end else begin
            ev = 3'd0;
            if (keyIn != m_level) begin
                if (keyIn) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    ev = (m_len >= DAH_U * U) ? 3'd2 : 3'd1;
                    m_phase = 2;
                end
                m_level = keyIn;
                m_len = 1;
            end else begin
                if (m_len < 100000) m_len++;
                if (m_phase == 2 && m_len == GAP_U * U) ev = 3'd3;
                if (m_phase == 2 && m_len == SPACE_U * U) begin
                    ev = 3'd4;
                    m_phase = 0;
                end
            end
            m_out = d2; d2 = d1; d1 = ev;
            m_kl = m_s1; m_s1 = keyIn;
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            if (inputSignal != 3'd0) seen.push_back(cyc * 8 + int'(inputSignal));
            if (m_out != 3'd0) want.push_back(cyc * 8 + int'(m_out));
        end
    end

    task automatic hold(input logic lvl, input int n);
        keyIn = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int exp_s[3];
        exp_s = '{1, 3, 4};
        resetN = 1'b0;
        keyIn = 1'b1;
        repeat (3) @(negedge clk);
        nchecks++;
        if (inputSignal !== 3'd0) begin
            nerr++;
            $display("FAIL reset_sym: got %0d want 0", inputSignal);
        end
        nchecks++;
        if (keyLevel !== 1'b0) begin
            nerr++;
            $display("FAIL reset_level: got %0b want 0", keyLevel);
        end
        resetN = 1'b1;
        seen.delete(); want.delete();
        hold(1'b1, 12);
        resetN = 1'b0;
        hold(1'b1, 2);
        nchecks++;
        if (inputSignal !== 3'd0 || keyLevel !== 1'b0) begin
            nerr++;
            $display("FAIL reset_pulse: got sym %0d lvl %0b want 0 0", inputSignal, keyLevel);
        end
        resetN = 1'b1;
        hold(1'b1, 3);
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 3) begin
            nerr++;
            $display("FAIL reset_abort_count: got %0d symbols want 3", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL reset_abort_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
        end
        nchecks++;
        if (seen != want) begin
            nerr++;
            $display("FAIL reset_model: got %0d symbols want %0d", seen.size(), want.size());
        end
    endtask

    task automatic test_letter_e();
        int fall;
        int exp_s[3];
        exp_s = '{1, 3, 4};
        seen.delete(); want.delete();
        hold(1'b1, 4);
        fall = cyc;
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 3) begin
            nerr++;
            $display("FAIL e_count: got %0d symbols want 3", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL e_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
            nchecks++;
            if (seen[0] / 8 != fall + 3) begin
                nerr++;
                $display("FAIL e_dit_latency: got %0d want %0d", seen[0] / 8 - fall, 3);
            end
            nchecks++;
            if (seen[1] / 8 - seen[0] / 8 < 11 || seen[1] / 8 - seen[0] / 8 > 13) begin
                nerr++;
                $display("FAIL e_gap_delay: got %0d want 11..13", seen[1] / 8 - seen[0] / 8);
            end
            nchecks++;
            if (seen[2] / 8 - seen[1] / 8 < 15 || seen[2] / 8 - seen[1] / 8 > 17) begin
                nerr++;
                $display("FAIL e_space_delay: got %0d want 15..17", seen[2] / 8 - seen[1] / 8);
            end
        end
        nchecks++;
        if (seen != want) begin
            nerr++;
            $display("FAIL e_model: got %0d symbols want %0d", seen.size(), want.size());
        end
    endtask

    task automatic test_letter_b();
        int exp_s[6];
        exp_s = '{2, 1, 1, 1, 3, 4};
        seen.delete(); want.delete();
        hold(1'b1, 12);
        repeat (3) begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 6) begin
            nerr++;
            $display("FAIL b_count: got %0d symbols want 6", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL b_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
        end
        nchecks++;
        if (seen != want) begin
            nerr++;
            $display("FAIL b_model: got %0d symbols want %0d", seen.size(), want.size());
        end
    endtask

    task automatic test_gap_boundary();
        int exp_s[6];
        exp_s = '{1, 1, 3, 1, 3, 4};
        seen.delete(); want.delete();
        hold(1'b1, 4);
        hold(1'b0, 8);
        hold(1'b1, 4);
        hold(1'b0, 12);
        hold(1'b1, 4);
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 6) begin
            nerr++;
            $display("FAIL gap_count: got %0d symbols want 6", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL gap_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
        end
        nchecks++;
        if (seen != want) begin
            nerr++;
            $display("FAIL gap_model: got %0d symbols want %0d", seen.size(), want.size());
        end
    endtask

    task automatic test_long_hold();
        int exp_s[3];
        exp_s = '{2, 3, 4};
        seen.delete(); want.delete();
        hold(1'b1, 100);
        nchecks++;
        if (seen.size() != 0) begin
            nerr++;
            $display("FAIL hold_quiet: got %0d symbols want 0", seen.size());
        end
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 3) begin
            nerr++;
            $display("FAIL hold_count: got %0d symbols want 3", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL hold_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
        end
        nchecks++;
        if (seen != want) begin
            nerr++;
            $display("FAIL hold_model: got %0d symbols want %0d", seen.size(), want.size());
        end
    endtask

    task automatic test_reset_letter_gap();
        int exp_s[2];
        exp_s = '{1, 3};
        seen.delete(); want.delete();
        hold(1'b1, 4);
        hold(1'b0, 20);
        nchecks++;
        if (dut.state !== LETTER_GAP) begin
            nerr++;
            $display("FAIL lg_state_before: got %0d want %0d", dut.state, LETTER_GAP);
        end
        resetN = 1'b0;
        #1;
        nchecks++;
        if (inputSignal !== 3'd0 || dut.state !== IDLE) begin
            nerr++;
            $display("FAIL lg_reset: got sym %0d state %0d want 0 %0d", inputSignal, dut.state, IDLE);
        end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        hold(1'b0, 40);
        nchecks++;
        if (seen.size() != 2) begin
            nerr++;
            $display("FAIL lg_count: got %0d symbols want 2", seen.size());
        end else begin
            foreach (exp_s[i]) begin
                nchecks++;
                if (seen[i] % 8 != exp_s[i]) begin
                    nerr++;
                    $display("FAIL lg_sym%0d: got %0d want %0d", i, seen[i] % 8, exp_s[i]);
                end
            end
        end
        nchecks++;
        if (dut.state !== IDLE) begin
            nerr++;
            $display("FAIL lg_state_after: got %0d want %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   n;
        int   lvl_err;
        for (int r = 0; r < 4; r++) begin
            seen.delete(); want.delete();
            lvl = 1'b1;
            lvl_err = 0;
            for (int s = 0; s < 14; s++) begin
                n = $urandom_range(1, 35);
                keyIn = lvl;
                repeat (n) begin
                    @(negedge clk);
                    nchecks++;
                    if (keyLevel !== m_kl) begin
                        nerr++;
                        if (lvl_err++ < 4)
                            $display("FAIL rnd_level: got %0b want %0b", keyLevel, m_kl);
                    end
                end
                lvl = ~lvl;
            end
            hold(1'b0, 40);
            nchecks++;
            if (seen.size() != want.size()) begin
                nerr++;
                $display("FAIL rnd_count%0d: got %0d symbols want %0d", r, seen.size(), want.size());
            end else begin
                foreach (want[i]) begin
                    nchecks++;
                    if (seen[i] !== want[i]) begin
                        nerr++;
                        $display("FAIL rnd_sym%0d_%0d: got cyc %0d sym %0d want cyc %0d sym %0d",
                                 r, i, seen[i] / 8, seen[i] % 8, want[i] / 8, want[i] % 8);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_b();
        test_gap_boundary();
        test_long_hold();
        test_reset_letter_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
